hwpe_stream_serializer: RTL and testbench

HWPE_STREAM_SERIALIZER -- requirements
Module: hwpe_stream_serializer

---
 rtl/hwpe_stream_serializer_pkg.sv | 17 +
 rtl/hwpe_stream_intf_stream.sv | 14 +
 rtl/hwpe_stream_serializer.sv | 112 +++++++++++
 tb/tb_hwpe_stream_serializer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_stream_serializer_pkg.sv
// Shared status and state types for the wide-to-narrow stream serializer.
package hwpe_stream_package;

  // Fixed-width beat index so the struct can be shared by every RATIO (zero-extended).
  localparam int unsigned SERIALIZER_BEAT_W = 8;

  typedef struct packed {
    logic                         busy;
    logic [SERIALIZER_BEAT_W-1:0] beat;
  } flags_serializer_t;

  typedef enum logic {
    SER_IDLE   = 1'b0,
    SER_SERIAL = 1'b1
  } serializer_state_e;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle with byte strobes; source drives valid/data/strb, sink drives ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_serializer.sv
// Splits one wide stream word into RATIO narrow beats, LSB slice first.
// Latency: 1 cycle from input handshake to first output beat, 1 beat/cycle sustained.
// Backpressure: input ready only when empty or when the last beat is being accepted.
module hwpe_stream_serializer
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH_IN  = 128,
  parameter int unsigned DATA_WIDTH_OUT = 32,
  parameter bit          SKIP_EMPTY     = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  output flags_serializer_t      flags_o,
  hwpe_stream_intf_stream.sink   push_i,
  hwpe_stream_intf_stream.source pop_o
);

  localparam int unsigned RATIO    = DATA_WIDTH_IN / DATA_WIDTH_OUT;
  localparam int unsigned BW       = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned STRB_IN  = DATA_WIDTH_IN / 8;
  localparam int unsigned STRB_OUT = DATA_WIDTH_OUT / 8;

  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 ||
      DATA_WIDTH_IN != RATIO * DATA_WIDTH_OUT || (DATA_WIDTH_OUT % 32) != 0) begin : g_bad_ratio
    $fatal(1, "hwpe_stream_serializer: DATA_WIDTH_IN/DATA_WIDTH_OUT must be a power of two >= 2");
  end

  // Lowest slice index >= from with a non-zero strobe; MSB of the result is the found flag.
  function automatic logic [BW:0] first_nz_slice(input logic [STRB_IN-1:0] strb, input int from);
    logic [BW:0] res;
    res = '0;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (i >= from && |strb[i*STRB_OUT +: STRB_OUT]) begin
        res = {1'b1, BW'(i)};
      end
    end
    return res;
  endfunction

  serializer_state_e      state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [DATA_WIDTH_IN-1:0] data_q, data_d;
  logic [STRB_IN-1:0]     strb_q, strb_d;

  logic [BW:0] nz_next, nz_first;
  logic        pop_vld, is_last, pop_hs, push_rdy, push_hs;

  always_comb begin
    nz_next  = first_nz_slice(strb_q, int'(beat_q) + 1);
    nz_first = first_nz_slice(push_i.strb, 0);
    pop_vld  = (state_q == SER_SERIAL);
    is_last  = SKIP_EMPTY ? !nz_next[BW] : (beat_q == BW'(RATIO - 1));
    pop_hs   = pop_vld && pop_o.ready;
    push_rdy = !pop_vld || (pop_hs && is_last);
    push_hs  = push_i.valid && push_rdy;
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    data_d  = data_q;
    strb_d  = strb_q;
    if (pop_hs) begin
      if (is_last) begin
        state_d = SER_IDLE;
        beat_d  = '0;
      end else begin
        beat_d = SKIP_EMPTY ? nz_next[BW-1:0] : beat_q + BW'(1);
      end
    end
    if (push_hs) begin
      if (SKIP_EMPTY && !nz_first[BW]) begin
        state_d = SER_IDLE;
        beat_d  = '0;
      end else begin
        state_d = SER_SERIAL;
        beat_d  = SKIP_EMPTY ? nz_first[BW-1:0] : '0;
        data_d  = push_i.data;
        strb_d  = push_i.strb;
      end
    end
    if (clear_i) begin
      state_d = SER_IDLE;
      beat_d  = '0;
      data_d  = '0;
      strb_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SER_IDLE;
      beat_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
    end
  end

  assign push_i.ready = push_rdy;
  assign pop_o.valid  = pop_vld;
  assign pop_o.data   = pop_vld ? data_q[beat_q*DATA_WIDTH_OUT +: DATA_WIDTH_OUT] : '0;
  assign pop_o.strb   = pop_vld ? strb_q[beat_q*STRB_OUT +: STRB_OUT] : '0;
  assign flags_o.busy = pop_vld;
  assign flags_o.beat = SERIALIZER_BEAT_W'(beat_q);

endmodule

// File: tb/tb_hwpe_stream_serializer.sv
// Bench for two 128->32 serializers: dut0 emits every slice, dut1 skips empty-strobe slices.
module tb_hwpe_stream_serializer;
  import hwpe_stream_package::*;

  localparam int RATIO = 4;

  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  strb;
    logic [7:0]  idx;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         clr       [2];
  logic         push_vld  [2];
  logic [127:0] push_dat  [2];
  logic [15:0]  push_strb [2];
  logic         pop_rdy   [2];
  logic         push_rdy  [2];
  logic         pop_vld   [2];
  logic [31:0]  pop_dat   [2];
  logic [3:0]   pop_strb  [2];
  logic         busy      [2];
  logic [7:0]   beat      [2];
  flags_serializer_t f0, f1;

  hwpe_stream_intf_stream #(.DATA_WIDTH(128)) push0 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32))  pop0 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(128)) push1 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32))  pop1 ();

  assign push0.valid = push_vld[0];
  assign push0.data  = push_dat[0];
  assign push0.strb  = push_strb[0];
  assign push_rdy[0] = push0.ready;
  assign pop0.ready  = pop_rdy[0];
  assign pop_vld[0]  = pop0.valid;
  assign pop_dat[0]  = pop0.data;
  assign pop_strb[0] = pop0.strb;
  assign busy[0]     = f0.busy;
  assign beat[0]     = f0.beat;

  assign push1.valid = push_vld[1];
  assign push1.data  = push_dat[1];
  assign push1.strb  = push_strb[1];
  assign push_rdy[1] = push1.ready;
  assign pop1.ready  = pop_rdy[1];
  assign pop_vld[1]  = pop1.valid;
  assign pop_dat[1]  = pop1.data;
  assign pop_strb[1] = pop1.strb;
  assign busy[1]     = f1.busy;
  assign beat[1]     = f1.beat;

  hwpe_stream_serializer #(.DATA_WIDTH_IN(128), .DATA_WIDTH_OUT(32), .SKIP_EMPTY(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr[0]), .flags_o(f0), .push_i(push0), .pop_o(pop0)
  );
  hwpe_stream_serializer #(.DATA_WIDTH_IN(128), .DATA_WIDTH_OUT(32), .SKIP_EMPTY(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr[1]), .flags_o(f1), .push_i(push1), .pop_o(pop1)
  );

  int    n_checks;
  int    n_fail;
  bit    skip_cfg [2];
  beat_t exp_q [$];

  // Outstanding beats of the word being serialized, oldest first.
  function automatic void add_word(input int d, input logic [127:0] w, input logic [15:0] s);
    beat_t b;
    for (int i = 0; i < RATIO; i++) begin
      b.dat  = w[i*32 +: 32];
      b.strb = s[i*4 +: 4];
      b.idx  = 8'(i);
      if (!skip_cfg[d] || b.strb != 4'h0) exp_q.push_back(b);
    end
  endfunction

  function automatic logic [15:0] rand_strb();
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < RATIO; i++) begin
      case ($urandom_range(0, 3))
        0:       s[i*4 +: 4] = 4'h0;
        1:       s[i*4 +: 4] = 4'($urandom);
        default: s[i*4 +: 4] = 4'hF;
      endcase
    end
    if ($urandom_range(0, 7) == 0) s = '0;
    return s;
  endfunction

  // One cycle: check outputs against the model before the edge, then advance the model.
  task automatic step(input int d, output logic o_vld, output logic [31:0] o_dat,
                      output logic o_rdy, output logic [7:0] o_beat);
    logic  e_vld, e_rdy;
    beat_t fr;
    @(negedge clk);
    e_vld = (exp_q.size() != 0);
    e_rdy = !e_vld || (exp_q.size() == 1 && pop_rdy[d]);
    fr = e_vld ? exp_q[0] : '0;
    o_vld = pop_vld[d]; o_dat = pop_dat[d]; o_rdy = push_rdy[d]; o_beat = beat[d];
    n_checks++;
    if (pop_vld[d] !== e_vld) begin
      n_fail++; $display("FAIL pop_valid dut%0d t=%0t: got %b want %b", d, $time, pop_vld[d], e_vld);
    end
    n_checks++;
    if (pop_dat[d] !== fr.dat) begin
      n_fail++; $display("FAIL pop_data dut%0d t=%0t: got %h want %h", d, $time, pop_dat[d], fr.dat);
    end
    n_checks++;
    if (pop_strb[d] !== fr.strb) begin
      n_fail++; $display("FAIL pop_strb dut%0d t=%0t: got %h want %h", d, $time, pop_strb[d], fr.strb);
    end
    n_checks++;
    if (beat[d] !== fr.idx) begin
      n_fail++; $display("FAIL flags_beat dut%0d t=%0t: got %0d want %0d", d, $time, beat[d], fr.idx);
    end
    n_checks++;
    if (busy[d] !== e_vld) begin
      n_fail++; $display("FAIL flags_busy dut%0d t=%0t: got %b want %b", d, $time, busy[d], e_vld);
    end
    n_checks++;
    if (push_rdy[d] !== e_rdy) begin
      n_fail++; $display("FAIL push_ready dut%0d t=%0t: got %b want %b", d, $time, push_rdy[d], e_rdy);
    end
    if (rst || clr[d]) begin
      exp_q.delete();
    end else begin
      if (e_vld && pop_rdy[d]) void'(exp_q.pop_front());
      if (push_vld[d] && e_rdy) add_word(d, push_dat[d], push_strb[d]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (pop_vld[d] !== 1'b0 || pop_dat[d] !== 32'h0 || pop_strb[d] !== 4'h0) begin
        n_fail++; $display("FAIL reset_pop dut%0d: got vld=%b dat=%h strb=%h want 0/0/0",
                           d, pop_vld[d], pop_dat[d], pop_strb[d]);
      end
      n_checks++;
      if (push_rdy[d] !== 1'b1 || busy[d] !== 1'b0 || beat[d] !== 8'd0) begin
        n_fail++; $display("FAIL reset_flags dut%0d: got rdy=%b busy=%b beat=%0d want 1/0/0",
                           d, push_rdy[d], busy[d], beat[d]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_basic();
    logic v, r; logic [31:0] dat; logic [7:0] bt;
    logic [31:0] want [4];
    want = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
    push_dat[0] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    push_strb[0] = 16'hFFFF; push_vld[0] = 1'b1; pop_rdy[0] = 1'b1;
    step(0, v, dat, r, bt);
    push_vld[0] = 1'b0;
    n_checks++;
    if (r !== 1'b1 || v !== 1'b0) begin
      n_fail++; $display("FAIL basic_accept: got rdy=%b vld=%b want 1/0", r, v);
    end
    for (int k = 0; k < 4; k++) begin
      step(0, v, dat, r, bt);
      n_checks++;
      if (v !== 1'b1 || dat !== want[k]) begin
        n_fail++; $display("FAIL basic_beat%0d: got vld=%b dat=%h want 1/%h", k, v, dat, want[k]);
      end
    end
    step(0, v, dat, r, bt);
    n_checks++;
    if (v !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: got vld=%b want 0", v);
    end
  endtask

  task automatic test_back_to_back();
    logic v, r; logic [31:0] dat; logic [7:0] bt;
    logic [127:0] words [3];
    int sent;
    for (int k = 0; k < 3; k++) words[k] = {$urandom, $urandom, $urandom, $urandom};
    push_dat[0] = words[0]; push_strb[0] = 16'hFFFF; push_vld[0] = 1'b1; pop_rdy[0] = 1'b1;
    step(0, v, dat, r, bt);
    sent = 1;
    push_dat[0] = words[1];
    for (int k = 0; k < 12; k++) begin
      step(0, v, dat, r, bt);
      n_checks++;
      if (v !== 1'b1 || r !== (k % 4 == 3)) begin
        n_fail++; $display("FAIL b2b_beat%0d: got vld=%b rdy=%b want 1/%b", k, v, r, (k % 4 == 3));
      end
      if (r && push_vld[0]) begin
        sent++;
        if (sent < 3) push_dat[0] = words[sent];
        else push_vld[0] = 1'b0;
      end
    end
    step(0, v, dat, r, bt);
  endtask

  task automatic test_backpressure();
    logic v, r; logic [31:0] dat; logic [7:0] bt;
    int got;
    got = 0;
    push_dat[0] = {$urandom, $urandom, $urandom, $urandom};
    push_strb[0] = 16'hFFFF; push_vld[0] = 1'b1; pop_rdy[0] = 1'b1;
    step(0, v, dat, r, bt);
    push_vld[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      pop_rdy[0] = (k % 2 == 0);
      step(0, v, dat, r, bt);
      if (v && pop_rdy[0]) got++;
    end
    n_checks++;
    if (got !== 4) begin
      n_fail++; $display("FAIL bp_count: got %0d beats want 4", got);
    end
    pop_rdy[0] = 1'b1;
    step(0, v, dat, r, bt);
  endtask

  task automatic test_skip_empty();
    logic v, r; logic [31:0] dat; logic [7:0] bt;
    logic [7:0] idxs [2];
    int nb;
    nb = 0; idxs[0] = 8'hFF; idxs[1] = 8'hFF;
    push_dat[1] = {$urandom, $urandom, $urandom, $urandom};
    push_strb[1] = 16'h0F0F; push_vld[1] = 1'b1; pop_rdy[1] = 1'b1;
    step(1, v, dat, r, bt);
    push_vld[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1, v, dat, r, bt);
      if (v) begin
        if (nb < 2) idxs[nb] = bt;
        nb++;
      end
    end
    n_checks++;
    if (nb !== 2 || idxs[0] !== 8'd0 || idxs[1] !== 8'd2) begin
      n_fail++; $display("FAIL skip_0f0f: got %0d beats idx %0d,%0d want 2 beats idx 0,2",
                         nb, idxs[0], idxs[1]);
    end
    push_strb[1] = 16'h0000; push_vld[1] = 1'b1;
    step(1, v, dat, r, bt);
    push_vld[1] = 1'b0;
    n_checks++;
    if (r !== 1'b1) begin
      n_fail++; $display("FAIL skip_zero_accept: got rdy=%b want 1", r);
    end
    for (int k = 0; k < 2; k++) begin
      step(1, v, dat, r, bt);
      n_checks++;
      if (v !== 1'b0 || busy[1] !== 1'b0) begin
        n_fail++; $display("FAIL skip_zero_idle%0d: got vld=%b busy=%b want 0/0", k, v, busy[1]);
      end
    end
  endtask

  task automatic test_clear_reset();
    logic v, r; logic [31:0] dat; logic [7:0] bt;
    logic [127:0] w;
    pop_rdy[0] = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      push_dat[0] = {$urandom, $urandom, $urandom, $urandom};
      push_strb[0] = 16'hFFFF; push_vld[0] = 1'b1;
      step(0, v, dat, r, bt);
      push_vld[0] = 1'b0;
      step(0, v, dat, r, bt);
      if (pass == 1) step(0, v, dat, r, bt);
      if (pass == 0) clr[0] = 1'b1; else rst = 1'b1;
      step(0, v, dat, r, bt);
      clr[0] = 1'b0; rst = 1'b0;
      n_checks++;
      if (bt !== 8'(pass + 1)) begin
        n_fail++; $display("FAIL abort%0d_beat: got %0d want %0d", pass, bt, pass + 1);
      end
      step(0, v, dat, r, bt);
      n_checks++;
      if (v !== 1'b0 || dat !== 32'h0 || bt !== 8'd0 || r !== 1'b1) begin
        n_fail++; $display("FAIL abort%0d_after: got vld=%b dat=%h beat=%0d rdy=%b want 0/0/0/1",
                           pass, v, dat, bt, r);
      end
      w = {$urandom, $urandom, $urandom, $urandom};
      push_dat[0] = w; push_vld[0] = 1'b1;
      step(0, v, dat, r, bt);
      push_vld[0] = 1'b0;
      step(0, v, dat, r, bt);
      n_checks++;
      if (v !== 1'b1 || dat !== w[31:0] || bt !== 8'd0) begin
        n_fail++; $display("FAIL abort%0d_restart: got vld=%b dat=%h beat=%0d want 1/%h/0",
                           pass, v, dat, bt, w[31:0]);
      end
      repeat (4) step(0, v, dat, r, bt);
    end
  endtask

  task automatic test_random(input int d, input int nwords);
    logic v, r; logic [31:0] dat; logic [7:0] bt;
    int acc, cyc;
    acc = 0; cyc = 0;
    push_vld[d] = 1'b0;
    while (acc < nwords && cyc < 4000) begin
      if (!push_vld[d] && $urandom_range(0, 2) != 0) begin
        push_dat[d]  = {$urandom, $urandom, $urandom, $urandom};
        push_strb[d] = rand_strb();
        push_vld[d]  = 1'b1;
      end
      pop_rdy[d] = ($urandom_range(0, 3) != 0);
      step(d, v, dat, r, bt);
      if (push_vld[d] && r) begin
        acc++;
        push_vld[d] = 1'b0;
      end
      cyc++;
    end
    push_vld[d] = 1'b0;
    n_checks++;
    if (acc !== nwords) begin
      n_fail++; $display("FAIL random%0d_timeout: accepted %0d words want %0d", d, acc, nwords);
    end
    pop_rdy[d] = 1'b1;
    repeat (6) step(d, v, dat, r, bt);
    n_checks++;
    if (v !== 1'b0) begin
      n_fail++; $display("FAIL random%0d_drain: got vld=%b want 0", d, v);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    skip_cfg[0] = 1'b0;
    skip_cfg[1] = 1'b1;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      clr[d] = 1'b0; push_vld[d] = 1'b0; push_dat[d] = '0; push_strb[d] = '0; pop_rdy[d] = 1'b0;
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_skip_empty();
    test_clear_reset();
    test_random(0, 40);
    test_random(1, 40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
